// File: rtl/fan_pwm_gen.sv
// ============================================================================
// Module   : fan_pwm_gen
// Brief    : Debounced 4-bit fan-speed switch to fixed-frequency PWM, with a
//            full-duty kick from standstill. Optional soft-start ramp is
//            enabled by defining FAN_PWM_SOFTSTART_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fan_pwm_gen #(
   parameter int unsigned ClkFreqHz      = 50_000_000,
   parameter int unsigned PwmFreqHz      = 25_000,
   parameter int unsigned DebounceCycles = 1_000_000,
   parameter int unsigned KickPeriods    = 500,
   parameter int unsigned RampPeriods    = 250
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic [3:0] pwm_setting_i,
   output logic       fan_pwm_o,
   output logic [3:0] level_o,
   output logic       kick_o
);

   localparam int unsigned P  = ClkFreqHz / PwmFreqHz;
   localparam int unsigned CW = $clog2(P);
   localparam int unsigned TW = $clog2(P + 1);
   localparam int unsigned DW = (DebounceCycles > 1) ? $clog2(DebounceCycles) : 1;
   localparam int unsigned KW = (KickPeriods > 1) ? $clog2(KickPeriods) : 1;

   if (P < 16) begin : g_chk_period
      $error("fan_pwm_gen: ClkFreqHz / PwmFreqHz must be at least 16");
   end
   if (DebounceCycles < 1) begin : g_chk_debounce
      $error("fan_pwm_gen: DebounceCycles must be at least 1");
   end
   if (KickPeriods < 1) begin : g_chk_kick
      $error("fan_pwm_gen: KickPeriods must be at least 1");
   end

   typedef enum logic [1:0] {
      StOff  = 2'd0,
      StKick = 2'd1,
      StRun  = 2'd2
   } state_e;

   // Per-level high time in cycles, floor(l*P/15); level 15 yields P (always on).
   logic [TW-1:0] thr_w [16];
   for (genvar l = 0; l < 16; l++) begin : g_thr
      assign thr_w[l] = TW'((64'(l) * 64'(P)) / 64'd15);
   end

   logic [3:0]    sync0_q, sync1_q;
   logic [3:0]    cand_q, cand_d;
   logic [3:0]    target_q, target_d;
   logic [DW-1:0] dcnt_q, dcnt_d;

   always_comb begin
      cand_d   = cand_q;
      dcnt_d   = dcnt_q;
      target_d = target_q;
      if (sync1_q != cand_q) begin
         cand_d = sync1_q;
         dcnt_d = '0;
      end else if (dcnt_q != DW'(DebounceCycles - 1)) begin
         dcnt_d = dcnt_q + DW'(1);
      end
      // Evaluated on the next count so the target lands 2 + DebounceCycles after the pin.
      if (dcnt_d == DW'(DebounceCycles - 1)) begin
         target_d = cand_d;
      end
   end

   logic [CW-1:0] cnt_q, cnt_d;
   logic          boundary;

   assign boundary = (cnt_q == CW'(P - 1));
   assign cnt_d    = boundary ? '0 : cnt_q + CW'(1);

   state_e        state_q, state_d;
   logic [3:0]    level_q, level_d;
   logic [KW-1:0] kick_q, kick_d;
   logic          pwm_q, pwm_d;

`ifdef FAN_PWM_SOFTSTART_EN
   localparam int unsigned RW = (RampPeriods > 1) ? $clog2(RampPeriods) : 1;
   logic [RW-1:0] ramp_q, ramp_d;
`else
   // RampPeriods has no role without soft start.
   if (RampPeriods == 0) begin : g_ramp_unused
   end
`endif

   always_comb begin
      state_d = state_q;
      level_d = level_q;
      kick_d  = kick_q;
`ifdef FAN_PWM_SOFTSTART_EN
      ramp_d  = ramp_q;
`endif
      if (boundary) begin
         unique case (state_q)
            StOff: begin
               level_d = '0;
               if (target_q != 4'd0) begin
                  state_d = StKick;
                  kick_d  = '0;
               end
            end
            StKick: begin
               if (kick_q == KW'(KickPeriods - 1)) begin
                  state_d = StRun;
`ifdef FAN_PWM_SOFTSTART_EN
                  level_d = 4'd1;
                  ramp_d  = '0;
`else
                  level_d = target_q;
`endif
               end else begin
                  kick_d = kick_q + KW'(1);
               end
            end
            StRun: begin
`ifdef FAN_PWM_SOFTSTART_EN
               if (level_q == 4'd0 && target_q == 4'd0) begin
                  state_d = StOff;
               end else if (ramp_q == RW'(RampPeriods - 1)) begin
                  ramp_d = '0;
                  if (level_q < target_q) begin
                     level_d = level_q + 4'd1;
                  end else if (level_q > target_q) begin
                     level_d = level_q - 4'd1;
                  end
               end else begin
                  ramp_d = ramp_q + RW'(1);
               end
`else
               level_d = target_q;
               if (target_q == 4'd0) begin
                  state_d = StOff;
               end
`endif
            end
            default: begin
               state_d = StOff;
               level_d = '0;
            end
         endcase
      end
   end

   // Output is registered against the next count so the high phase starts right after a boundary.
   always_comb begin
      pwm_d = 1'b0;
      unique case (state_d)
         StKick:  pwm_d = 1'b1;
         StRun:   pwm_d = (TW'(cnt_d) < thr_w[level_d]);
         default: pwm_d = 1'b0;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync0_q  <= '0;
         sync1_q  <= '0;
         cand_q   <= '0;
         dcnt_q   <= '0;
         target_q <= '0;
         cnt_q    <= '0;
         state_q  <= StOff;
         level_q  <= '0;
         kick_q   <= '0;
         pwm_q    <= 1'b0;
`ifdef FAN_PWM_SOFTSTART_EN
         ramp_q   <= '0;
`endif
      end else begin
         sync0_q  <= pwm_setting_i;
         sync1_q  <= sync0_q;
         cand_q   <= cand_d;
         dcnt_q   <= dcnt_d;
         target_q <= target_d;
         cnt_q    <= cnt_d;
         state_q  <= state_d;
         level_q  <= level_d;
         kick_q   <= kick_d;
         pwm_q    <= pwm_d;
`ifdef FAN_PWM_SOFTSTART_EN
         ramp_q   <= ramp_d;
`endif
      end
   end

   assign fan_pwm_o = pwm_q;
   assign level_o   = level_q;
   assign kick_o    = (state_q == StKick);

endmodule

`default_nettype wire

// File: doc/fan_pwm_gen.md
# fan_pwm_gen

PWM fan driver for the FPGA board top: debounces the 4-bit fan-speed DIP switches and produces a fixed-frequency PWM on the board fan pin. It runs in the 50 MHz SoC clock domain, next to the RTC divider and reset sync. A start-up kick phase guarantees spin-up from standstill. An optional soft-start ramp limits current steps on speed changes.

## Interface
- `ClkFreqHz`, default 50_000_000: `clk_i` frequency.
- `PwmFreqHz`, default 25_000: PWM frequency. `P = ClkFreqHz / PwmFreqHz` (integer division); elaboration fails if `P < 16`.
- `DebounceCycles`, default 1_000_000: cycles the synchronized switch value must be stable. Must be ≥1.
- `KickPeriods`, default 500: PWM periods at 100% duty when leaving OFF. Must be ≥1.
- `RampPeriods`, default 250: PWM periods per one-level ramp step. Used only with soft start.
- `clk_i`, input, 1: SoC clock.
- `rst_ni`, input, 1: reset; asynchronous, active-low.
- `pwm_setting_i`, input, 4: raw switch levels, asynchronous to `clk_i`.
- `fan_pwm_o`, output, 1: registered PWM output; 1 = fan powered.
- `level_o`, output, 4: duty level currently applied (0..15).
- `kick_o`, output, 1: high while in KICK.

## Operation
- **Sync:** two-flop synchronizer on `pwm_setting_i`, giving `sync`.
- **Debounce:**
  - If `sync != cand`: load `cand`, clear the stable counter.
  - Otherwise increment the counter, saturating.
  - When the counter reaches `DebounceCycles - 1`, `target <= cand`.
  - Net latency from a pin change to a `target` update is `2 + DebounceCycles` cycles.
  - Glitches shorter than `DebounceCycles` never reach `target`.
- **Period counter:** `cnt` runs 0..P-1 and wraps. A boundary is the cycle in which `cnt == P-1`.
  - All level and FSM state changes occur only at boundaries. Periods are never truncated.
- **Threshold:** `thr[l] = (l*P)/15`, floor, computed at elaboration. There is no runtime divider. `thr[0] = 0` and `thr[15] = P`.
- **FSM** (transitions evaluated at a boundary):
  - **OFF:** `level = 0`, output low. If `target != 0`: go to KICK and clear the kick counter.
  - **KICK:** output high for the whole period. The kick counter increments per period.
    - After `KickPeriods` periods, go to RUN. `level` = 1 with soft start, otherwise `target`.
    - If `target` returns to 0 during KICK, the kick still completes; RUN then immediately handles `target = 0`.
  - **RUN:** `fan_pwm_o` next = `cnt_next < thr[level]`.
    - Without soft start: `level <= target` at every boundary. If `target == 0`, go to OFF.
    - With soft start: every `RampPeriods` periods, `level` steps by ±1 toward `target`. Go to OFF only when `level` reaches 0 and `target == 0`.
- **Reset values (any time, including mid-period):** `fan_pwm_o = 0`, `level_o = 0`, `kick_o = 0`, state OFF, all counters 0, `cand = 0`, `target = 0`, synchronizer flops 0.

## Timing
- `fan_pwm_o` is a flop. In RUN it is high for exactly `thr[level]` consecutive cycles from the cycle after each boundary, then low for `P - thr[level]` cycles.
- A `target` change takes effect at the next boundary, so latency is at most P cycles after `target` updates. The kick adds `KickPeriods*P` cycles when leaving OFF.
- `level_o` and `kick_o` update in the same edge as the boundary transition.
- If a `target` update and a boundary fall in the same cycle, the old `target` is used. The new value applies at the following boundary.

## Configuration
- Macro: `FAN_PWM_SOFTSTART_EN`.
- **Defined:** the RUN ramp behaves as described; KICK exits at level 1; the ramp counter is instantiated.
- **Undefined:** `level` jumps to `target` at the boundary; `RampPeriods` is ignored; no ramp counter exists.

## Test plan
Bench parameters: `ClkFreqHz = 1600`, `PwmFreqHz = 100` (so P = 16), `DebounceCycles = 4`, `KickPeriods = 2`, `RampPeriods = 1`.

- **Reset and idle:** reset, `pwm_setting_i = 0` → `fan_pwm_o` stays 0 for 200 cycles; `level_o = 0`.
- **Kick then run (soft start off):** set `pwm_setting_i = 7` → `target = 7` after 6 cycles; at the next boundary `kick_o = 1` and the output is high for 32 cycles; then `level_o = 7` and the output is high 7 / low 9 per period.
- **Debounce:** a 3-cycle pulse of `pwm_setting_i = 15` on an idle fan → `target` stays 0, no kick; holding it 4 stable cycles → `target = 15`; in RUN the output is constant 1 (thr = 16).
- **Soft-start ramp (macro defined):** setting 0→4 → after the kick, `level_o` goes 1, 2, 3, 4 on consecutive boundaries; then setting 4→0 → `level_o` goes 3, 2, 1, 0, then OFF.
- **Async reset mid-high-phase:** at level 15 in RUN, pulse `rst_ni` low → `fan_pwm_o` and `level_o` drop to 0 without waiting for a clock edge; after release, a new kick occurs since the setting is still 15.
- **Change at a boundary:** a `target` update in the `cnt == 15` cycle → the old level holds one more period, and the new level applies at the following boundary.
